lsu_bram_master: RTL and testbench

- Load/store initiator that drives one port of the dual-port data BRAM on behalf of the CPU memory stage.
- Accepts RV32I load/store requests over a valid/ready handshake and generates the word address, per-byte write strobes and lane-shifted write data.
- Absorbs the BRAM's one-cycle registered read latency, then extracts, sign- or zero-extends and returns load data.
- Optionally splits word-crossing misaligned accesses into two BRAM accesses.

---
 rtl/lsu_bram_master_if.sv | 24 ++
 rtl/lsu_bram_master.sv | 150 +++++++++++++++
 tb/tb_lsu_bram_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lsu_bram_master_if.sv
// lsu_bram_master_if: request/response handshake plus BRAM port bundle for lsu_bram_master
interface lsu_bram_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_do;
  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_do,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_di
  );
  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_do,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_we, mem_addr, mem_di
  );
endinterface

// File: rtl/lsu_bram_master.sv
// lsu_bram_master: RV32I load/store initiator for one BRAM port; define MISALIGN_SPLIT_EN to split word-crossing accesses
module lsu_bram_master #(
  parameter logic [31:0] DMEM_START = 32'h00005000,
  parameter logic [31:0] DMEM_END   = 32'h00008000
) (
  input logic clk,
  input logic rst,
  lsu_bram_master_if.master bus
);
  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    CAPT
`ifdef MISALIGN_SPLIT_EN
    , ACC1
`endif
  } state_t;
  state_t      state_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        err_pend_q;
  logic [3:0]  mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_di_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_rdata_q;
  logic [1:0]  off;
  logic [2:0]  size;
  logic [3:0]  mask;
  logic [32:0] last;
  logic        legal;
  logic        in_range;
  logic        err;
  logic [63:0] raw;
  assign off = bus.req_addr[1:0];
  assign size = bus.req_funct3[1] ? 3'd4 : bus.req_funct3[0] ? 3'd2 : 3'd1;
  assign mask = {bus.req_funct3[1], bus.req_funct3[1], |bus.req_funct3[1:0], 1'b1};
  assign last = {1'b0, bus.req_addr} + {30'b0, size} - 33'd1;
  assign legal = bus.req_we ? (!bus.req_funct3[2] && bus.req_funct3[1:0] != 2'b11)
                            : !(bus.req_funct3[1] && (bus.req_funct3[0] || bus.req_funct3[2]));
  assign in_range = bus.req_addr >= DMEM_START && last < {1'b0, DMEM_END};
`ifdef MISALIGN_SPLIT_EN
  logic        split_q;
  logic [3:0]  we1_q;
  logic [31:0] di1_q;
  logic [31:0] lo_q;
  logic        cross;
  logic [7:0]  strb;
  logic [63:0] wide;
  assign cross = ({1'b0, off} + size) > 3'd4;
  assign strb = {4'b0, mask} << off;
  assign wide = {32'b0, bus.req_wdata} << {off, 3'b000};
  assign err = !legal || !in_range;
  assign raw = split_q ? {bus.mem_do, lo_q} : {32'b0, bus.mem_do};
`else
  logic [3:0]  strb;
  logic [31:0] wide;
  logic [1:0]  amask;
  assign amask = {bus.req_funct3[1], |bus.req_funct3[1:0]};
  assign strb = mask << off;
  assign wide = bus.req_wdata << {off, 3'b000};
  assign err = !legal || !in_range || |(off & amask);
  assign raw = {32'b0, bus.mem_do};
`endif
  function automatic logic [31:0] ext(input logic [63:0] r, input logic [1:0] o, input logic [2:0] f);
    logic [31:0] v;
    v = 32'(r >> {o, 3'b000});
    ext = f[1] ? v : f[0] ? {{16{~f[2] & v[15]}}, v[15:0]} : {{24{~f[2] & v[7]}}, v[7:0]};
  endfunction
  // Access sequencer: accept, drive BRAM word(s), capture read data and pulse the response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'b0;
      off_q       <= 2'b0;
      err_pend_q  <= 1'b0;
      mem_we_q    <= 4'b0;
      mem_addr_q  <= 32'b0;
      mem_di_q    <= 32'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      we1_q       <= 4'b0;
      di1_q       <= 32'b0;
      lo_q        <= 32'b0;
`endif
    end else begin
      rsp_valid_q <= err_pend_q;
      rsp_err_q   <= err_pend_q;
      rsp_rdata_q <= 32'b0;
      err_pend_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.req_valid) begin
          we_q  <= bus.req_we;
          f3_q  <= bus.req_funct3;
          off_q <= off;
          if (err) err_pend_q <= 1'b1;
          else begin
            state_q    <= ACC0;
            mem_addr_q <= {bus.req_addr[31:2], 2'b00};
            mem_we_q   <= bus.req_we ? strb[3:0] : 4'b0;
            mem_di_q   <= wide[31:0];
`ifdef MISALIGN_SPLIT_EN
            split_q    <= cross;
            we1_q      <= bus.req_we ? strb[7:4] : 4'b0;
            di1_q      <= wide[63:32];
`endif
          end
        end
        ACC0:
`ifdef MISALIGN_SPLIT_EN
          if (split_q) begin
            state_q    <= ACC1;
            mem_addr_q <= mem_addr_q + 32'd4;
            mem_we_q   <= we1_q;
            mem_di_q   <= di1_q;
          end else
`endif
          begin
            state_q  <= CAPT;
            mem_we_q <= 4'b0;
          end
`ifdef MISALIGN_SPLIT_EN
        ACC1: begin
          state_q  <= CAPT;
          mem_we_q <= 4'b0;
          lo_q     <= bus.mem_do;
        end
`endif
        CAPT: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= we_q ? 32'b0 : ext(raw, off_q, f3_q);
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_di    = mem_di_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_lsu_bram_master.sv
// tb_lsu_bram_master: directed self-checking bench for lsu_bram_master with a read-first BRAM model
module tb_lsu_bram_master;
  logic clk;
  logic rst;
  int checks;
  int errors;
  logic [3:0]  a0_we;
  logic [31:0] a0_addr;
  logic [31:0] a0_di;
  logic [31:0] a1_addr;
  logic [31:0] ram [0:4095];
  logic [31:0] do_q;
  lsu_bram_master_if bus ();
  lsu_bram_master dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Read-first synchronous BRAM port
  always @(posedge clk) begin
    do_q <= ram[bus.mem_addr[13:2]];
    for (int k = 0; k < 4; k++)
      if (bus.mem_we[k]) ram[bus.mem_addr[13:2]][8*k +: 8] <= bus.mem_di[8*k +: 8];
  end
  assign bus.mem_do = do_q;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int lat, input logic e, input logic [31:0] rd);
    int n;
    logic wseen;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    step();
    bus.req_valid = 1'b0;
    bus.req_we = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    a0_we = bus.mem_we;
    a0_addr = bus.mem_addr;
    a0_di = bus.mem_di;
    a1_addr = 32'hxxxxxxxx;
    wseen = |bus.mem_we;
    n = 0;
    while (!bus.rsp_valid && n < 6) begin
      step();
      n++;
      wseen |= |bus.mem_we;
      if (n == 1) a1_addr = bus.mem_addr;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " err"}, {31'b0, bus.rsp_err}, {31'b0, e});
    chk({tag, " rdata"}, bus.rsp_rdata, rd);
    if (e) chk({tag, " no write"}, {31'b0, wseen}, 32'h0);
  endtask
  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    #2;
    chk("reset req_ready", {31'b0, bus.req_ready}, 32'h1);
    chk("reset mem_we", {28'b0, bus.mem_we}, 32'h0);
    chk("reset mem_addr", bus.mem_addr, 32'h0);
    chk("reset mem_di", bus.mem_di, 32'h0);
    chk("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("reset rsp_err", {31'b0, bus.rsp_err}, 32'h0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    txn("SW 5000", 1'b1, 3'b010, 32'h5000, 32'hDEADBEEF, 2, 1'b0, 32'h0);
    chk("SW 5000 acc we", {28'b0, a0_we}, 32'hF);
    chk("SW 5000 acc addr", a0_addr, 32'h5000);
    chk("SW 5000 acc di", a0_di, 32'hDEADBEEF);
    txn("LW 5000", 1'b0, 3'b010, 32'h5000, 32'h0, 2, 1'b0, 32'hDEADBEEF);
    chk("LW 5000 acc we", {28'b0, a0_we}, 32'h0);
    step();
    chk("rsp pulse single", {31'b0, bus.rsp_valid}, 32'h0);
    txn("SW 80FF1234", 1'b1, 3'b010, 32'h5000, 32'h80FF1234, 2, 1'b0, 32'h0);
    txn("LB 5003", 1'b0, 3'b000, 32'h5003, 32'h0, 2, 1'b0, 32'hFFFFFF80);
    txn("LBU 5003", 1'b0, 3'b100, 32'h5003, 32'h0, 2, 1'b0, 32'h00000080);
    txn("LH 5002", 1'b0, 3'b001, 32'h5002, 32'h0, 2, 1'b0, 32'hFFFF80FF);
    txn("LHU 5000", 1'b0, 3'b101, 32'h5000, 32'h0, 2, 1'b0, 32'h00001234);
    txn("SB 5002", 1'b1, 3'b000, 32'h5002, 32'h000000AB, 2, 1'b0, 32'h0);
    chk("SB 5002 we", {28'b0, a0_we}, 32'h4);
    chk("SB 5002 lane", {24'b0, a0_di[23:16]}, 32'hAB);
    txn("LW after SB", 1'b0, 3'b010, 32'h5000, 32'h0, 2, 1'b0, 32'h80AB1234);
    txn("SH 5002", 1'b1, 3'b001, 32'h5002, 32'h0000ABCD, 2, 1'b0, 32'h0);
    chk("SH 5002 we", {28'b0, a0_we}, 32'hC);
    chk("SH 5002 lanes", {16'b0, a0_di[31:16]}, 32'hABCD);
    txn("LW after SH", 1'b0, 3'b010, 32'h5000, 32'h0, 2, 1'b0, 32'hABCD1234);
    txn("SW 5004", 1'b1, 3'b010, 32'h5004, 32'h44332211, 2, 1'b0, 32'h0);
    txn("SW 5008", 1'b1, 3'b010, 32'h5008, 32'h88776655, 2, 1'b0, 32'h0);
`ifdef MISALIGN_SPLIT_EN
    txn("LW 5006 split", 1'b0, 3'b010, 32'h5006, 32'h0, 3, 1'b0, 32'h66554433);
    chk("LW 5006 word0", a0_addr, 32'h5004);
    chk("LW 5006 word1", a1_addr, 32'h5008);
    txn("LH 5001", 1'b0, 3'b001, 32'h5001, 32'h0, 2, 1'b0, 32'hFFFFCD12);
`else
    txn("LW 5006 misaligned", 1'b0, 3'b010, 32'h5006, 32'h0, 1, 1'b1, 32'h0);
    txn("LH 5001 misaligned", 1'b0, 3'b001, 32'h5001, 32'h0, 1, 1'b1, 32'h0);
`endif
    txn("LW 4FFC range", 1'b0, 3'b010, 32'h4FFC, 32'h0, 1, 1'b1, 32'h0);
    txn("SH 7FFF range", 1'b1, 3'b001, 32'h7FFF, 32'h1234, 1, 1'b1, 32'h0);
    txn("SW 7FFC edge", 1'b1, 3'b010, 32'h7FFC, 32'h01020304, 2, 1'b0, 32'h0);
    txn("LW 7FFC edge", 1'b0, 3'b010, 32'h7FFC, 32'h0, 2, 1'b0, 32'h01020304);
    txn("funct3 011 load", 1'b0, 3'b011, 32'h5000, 32'h0, 1, 1'b1, 32'h0);
    txn("funct3 100 store", 1'b1, 3'b100, 32'h5000, 32'hFFFFFFFF, 1, 1'b1, 32'h0);
    txn("LW after bad store", 1'b0, 3'b010, 32'h5000, 32'h0, 2, 1'b0, 32'hABCD1234);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h5010;
    bus.req_wdata = 32'h12345678;
    step();
    bus.req_valid = 1'b0;
    chk("rstmid acc0 we", {28'b0, bus.mem_we}, 32'hF);
    chk("rstmid acc0 ready", {31'b0, bus.req_ready}, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rstmid async we", {28'b0, bus.mem_we}, 32'h0);
    chk("rstmid async valid", {31'b0, bus.rsp_valid}, 32'h0);
    step();
    step();
    chk("rstmid no rsp", {31'b0, bus.rsp_valid}, 32'h0);
    chk("rstmid ready", {31'b0, bus.req_ready}, 32'h1);
    rst = 1'b0;
    txn("LW after reset", 1'b0, 3'b010, 32'h5000, 32'h0, 2, 1'b0, 32'hABCD1234);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
